// File: rtl/usb_pkg.sv
// Shared constants for the USB device-side transaction layer:
// PID codes, sequencer state encoding and endpoint count.
package usb_pkg;

    localparam int NUM_EP = 16;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_TOKEN     = 4'd1,
        S_TOK_CHK   = 4'd2,
        S_DATA_WAIT = 4'd3,
        S_DATA_RX   = 4'd4,
        S_DATA_CHK  = 4'd5,
        S_HS_TX     = 4'd6,
        S_DATA_TX   = 4'd7,
        S_ACK_WAIT  = 4'd8
    } trans_state_e;

    function automatic logic is_token_pid(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) ||
               (pid == PID_SOF) || (pid == PID_SETUP);
    endfunction

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits. One endpoint is addressed per cycle;
// clear has priority over set, set over flip.
module usb_toggle_bank
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ep,
    input  logic       clr,
    input  logic       set,
    input  logic       flip,
    output logic       rd
);

    logic [NUM_EP-1:0] toggle_q;
    logic [NUM_EP-1:0] toggle_d;

    always_comb begin
        toggle_d = toggle_q;
        if (clr) begin
            toggle_d[ep] = 1'b0;
        end else if (set) begin
            toggle_d[ep] = 1'b1;
        end else if (flip) begin
            toggle_d[ep] = ~toggle_q[ep];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign rd = toggle_q[ep];

endmodule

// File: rtl/usb_trans_ctrl.sv
// Device-side USB transaction sequencer: token qualification, data phase,
// handshake phase, data-toggle bookkeeping and turnaround timeout.
module usb_trans_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100,
    parameter int CNT_W       = 8
) (
    input  logic        i_usb_trans_ctrl_clk,
    input  logic        i_usb_trans_ctrl_rst_n,
    input  logic [6:0]  i_usb_trans_ctrl_self_addr,
    input  logic [3:0]  i_usb_trans_ctrl_rx_pid,
    input  logic        i_usb_trans_ctrl_rx_pid_en,
    input  logic [6:0]  i_usb_trans_ctrl_rx_addr,
    input  logic [3:0]  i_usb_trans_ctrl_rx_endp,
    input  logic        i_usb_trans_ctrl_crc5_error,
    input  logic        i_usb_trans_ctrl_rx_valid,
    input  logic        i_usb_trans_ctrl_rx_eop,
    input  logic        i_usb_trans_ctrl_crc16_error,
    input  logic [15:0] i_usb_trans_ctrl_ep_stall,
    input  logic [15:0] i_usb_trans_ctrl_ep_tx_ready,
    input  logic [15:0] i_usb_trans_ctrl_ep_rx_ready,
    input  logic        i_usb_trans_ctrl_tx_done,
    output logic [3:0]  o_usb_trans_ctrl_tx_pid,
    output logic        o_usb_trans_ctrl_tx_req,
    output logic        o_usb_trans_ctrl_tx_is_data,
    output logic [3:0]  o_usb_trans_ctrl_ep_num,
    output logic        o_usb_trans_ctrl_rx_data_en,
    output logic        o_usb_trans_ctrl_rx_commit,
    output logic        o_usb_trans_ctrl_rx_handshake_on,
    output logic        o_usb_trans_ctrl_sof,
    output logic        o_usb_trans_ctrl_trans_done,
    output logic        o_usb_trans_ctrl_trans_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYC);

    logic        clk;
    logic        rst_n;
    logic [3:0]  rx_pid;
    logic        rx_pid_en;
    logic        rx_last;

    assign clk       = i_usb_trans_ctrl_clk;
    assign rst_n     = i_usb_trans_ctrl_rst_n;
    assign rx_pid    = i_usb_trans_ctrl_rx_pid;
    assign rx_pid_en = i_usb_trans_ctrl_rx_pid_en;
    assign rx_last   = i_usb_trans_ctrl_rx_valid & i_usb_trans_ctrl_rx_eop;

    trans_state_e     state_q, state_d;
    logic [3:0]       tok_pid_q, tok_pid_d;
    logic [3:0]       data_pid_q, data_pid_d;
    logic             addr_match_q, addr_match_d;
    logic [3:0]       ep_q, ep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tx_pid_q, tx_pid_d;
    logic             tx_req_q, tx_req_d;
    logic             tx_is_data_q, tx_is_data_d;
    logic             rx_data_en_q, rx_data_en_d;
    logic             rx_commit_q, rx_commit_d;
    logic             hs_on_q, hs_on_d;
    logic             sof_q, sof_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [3:0] ep_cur;
    logic       tog_clr, tog_set, tog_flip, tog_rd;

    // ENDP arrives only during TOK_CHK, so endpoint lookups there bypass ep_q.
    assign ep_cur = (state_q == S_TOK_CHK) ? i_usb_trans_ctrl_rx_endp : ep_q;

    usb_toggle_bank u_toggle_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .ep    (ep_cur),
        .clr   (tog_clr),
        .set   (tog_set),
        .flip  (tog_flip),
        .rd    (tog_rd)
    );

    always_comb begin
        state_d      = state_q;
        tok_pid_d    = tok_pid_q;
        data_pid_d   = data_pid_q;
        addr_match_d = addr_match_q;
        ep_d         = ep_q;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        tx_pid_d     = tx_pid_q;
        tx_req_d     = 1'b0;
        tx_is_data_d = tx_is_data_q;
        rx_commit_d  = 1'b0;
        sof_d        = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        tog_clr      = 1'b0;
        tog_set      = 1'b0;
        tog_flip     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_pid_en && is_token_pid(rx_pid)) begin
                    tok_pid_d = rx_pid;
                    state_d   = S_TOKEN;
                end
            end
            S_TOKEN: begin
                if (rx_pid_en) begin
                    if (is_token_pid(rx_pid)) begin
                        tok_pid_d = rx_pid;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (rx_last) begin
                    addr_match_d = (i_usb_trans_ctrl_rx_addr == i_usb_trans_ctrl_self_addr);
                    state_d      = S_TOK_CHK;
                end
            end
            S_TOK_CHK: begin
                ep_d    = i_usb_trans_ctrl_rx_endp;
                state_d = S_IDLE;
                if (i_usb_trans_ctrl_crc5_error) begin
                    state_d = S_IDLE;
                end else if (tok_pid_q == PID_SOF) begin
                    sof_d = 1'b1;
                end else if (!addr_match_q) begin
                    state_d = S_IDLE;
                end else if (tok_pid_q == PID_SETUP) begin
                    tog_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DATA_WAIT;
                end else if (tok_pid_q == PID_OUT) begin
                    cnt_d   = '0;
                    state_d = S_DATA_WAIT;
                end else if (i_usb_trans_ctrl_ep_stall[ep_cur]) begin
                    tx_req_d = 1'b1;
                    tx_pid_d = PID_STALL;
                    state_d  = S_HS_TX;
                end else if (!i_usb_trans_ctrl_ep_tx_ready[ep_cur]) begin
                    tx_req_d = 1'b1;
                    tx_pid_d = PID_NAK;
                    state_d  = S_HS_TX;
                end else begin
                    tx_req_d     = 1'b1;
                    tx_is_data_d = 1'b1;
                    tx_pid_d     = tog_rd ? PID_DATA1 : PID_DATA0;
                    state_d      = S_DATA_TX;
                end
            end
            S_DATA_WAIT: begin
                if (rx_pid_en) begin
                    if (is_data_pid(rx_pid)) begin
                        data_pid_d = rx_pid;
                        state_d    = S_DATA_RX;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_TO) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DATA_RX: begin
                if (rx_last) begin
                    state_d = S_DATA_CHK;
                end
            end
            S_DATA_CHK: begin
                state_d = S_IDLE;
                if (i_usb_trans_ctrl_crc16_error) begin
                    err_d = 1'b1;
                end else begin
                    tx_req_d = 1'b1;
                    state_d  = S_HS_TX;
                    if (tok_pid_q == PID_SETUP) begin
                        tx_pid_d    = PID_ACK;
                        rx_commit_d = 1'b1;
                        tog_set     = 1'b1;
                    end else if (i_usb_trans_ctrl_ep_stall[ep_cur]) begin
                        tx_pid_d = PID_STALL;
                    end else if (!i_usb_trans_ctrl_ep_rx_ready[ep_cur]) begin
                        tx_pid_d = PID_NAK;
                    end else begin
                        // A repeated packet (wrong toggle) is ACKed but dropped.
                        tx_pid_d = PID_ACK;
                        if ((data_pid_q == PID_DATA1) == tog_rd) begin
                            rx_commit_d = 1'b1;
                            tog_flip    = 1'b1;
                        end
                    end
                end
            end
            S_HS_TX: begin
                if (i_usb_trans_ctrl_tx_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DATA_TX: begin
                if (i_usb_trans_ctrl_tx_done) begin
                    cnt_d   = '0;
                    state_d = S_ACK_WAIT;
                end
            end
            S_ACK_WAIT: begin
                if (rx_pid_en) begin
                    state_d = S_IDLE;
                    if (rx_pid == PID_ACK) begin
                        tog_flip = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q == CNT_TO) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            tx_pid_d     = '0;
            tx_is_data_d = 1'b0;
        end
        rx_data_en_d = (state_d == S_DATA_RX);
        hs_on_d      = (state_d == S_ACK_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tok_pid_q    <= '0;
            data_pid_q   <= '0;
            addr_match_q <= 1'b0;
            ep_q         <= '0;
            cnt_q        <= '0;
            tx_pid_q     <= '0;
            tx_req_q     <= 1'b0;
            tx_is_data_q <= 1'b0;
            rx_data_en_q <= 1'b0;
            rx_commit_q  <= 1'b0;
            hs_on_q      <= 1'b0;
            sof_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tok_pid_q    <= tok_pid_d;
            data_pid_q   <= data_pid_d;
            addr_match_q <= addr_match_d;
            ep_q         <= ep_d;
            cnt_q        <= cnt_d;
            tx_pid_q     <= tx_pid_d;
            tx_req_q     <= tx_req_d;
            tx_is_data_q <= tx_is_data_d;
            rx_data_en_q <= rx_data_en_d;
            rx_commit_q  <= rx_commit_d;
            hs_on_q      <= hs_on_d;
            sof_q        <= sof_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign o_usb_trans_ctrl_tx_pid          = tx_pid_q;
    assign o_usb_trans_ctrl_tx_req          = tx_req_q;
    assign o_usb_trans_ctrl_tx_is_data      = tx_is_data_q;
    assign o_usb_trans_ctrl_ep_num          = ep_q;
    assign o_usb_trans_ctrl_rx_data_en      = rx_data_en_q;
    assign o_usb_trans_ctrl_rx_commit       = rx_commit_q;
    assign o_usb_trans_ctrl_rx_handshake_on = hs_on_q;
    assign o_usb_trans_ctrl_sof             = sof_q;
    assign o_usb_trans_ctrl_trans_done      = done_q;
    assign o_usb_trans_ctrl_trans_err       = err_q;

endmodule

// File: tb/tb_usb_trans_ctrl.sv
// Randomized transaction-level bench for usb_trans_ctrl against a
// per-transaction reference model of the USB protocol rules.
module tb_usb_trans_ctrl;
    import usb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  self_addr = 7'h05;
    logic [3:0]  rx_pid = '0;
    logic        rx_pid_en = 1'b0;
    logic [6:0]  rx_addr = '0;
    logic [3:0]  rx_endp = '0;
    logic        crc5_error = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_eop = 1'b0;
    logic        crc16_error = 1'b0;
    logic [15:0] ep_stall = '0;
    logic [15:0] ep_tx_ready = '0;
    logic [15:0] ep_rx_ready = '0;
    logic        tx_done = 1'b0;
    logic [3:0]  tx_pid;
    logic        tx_req;
    logic        tx_is_data;
    logic [3:0]  ep_num;
    logic        rx_data_en;
    logic        rx_commit;
    logic        rx_handshake_on;
    logic        sof;
    logic        trans_done;
    logic        trans_err;

    int total = 0;
    int bad = 0;
    int txn_id = 0;
    bit [15:0] model_tog = '0;

    // Pulse counters kept by the monitor; the bench works with deltas.
    int n_req = 0, n_commit = 0, n_sof = 0, n_done = 0, n_err = 0;
    logic [3:0] m_pid = '0, m_ep = '0;
    logic       m_isd = 1'b0;

    usb_trans_ctrl #(.TIMEOUT_CYC(100), .CNT_W(8)) dut (
        .i_usb_trans_ctrl_clk            (clk),
        .i_usb_trans_ctrl_rst_n          (rst_n),
        .i_usb_trans_ctrl_self_addr      (self_addr),
        .i_usb_trans_ctrl_rx_pid         (rx_pid),
        .i_usb_trans_ctrl_rx_pid_en      (rx_pid_en),
        .i_usb_trans_ctrl_rx_addr        (rx_addr),
        .i_usb_trans_ctrl_rx_endp        (rx_endp),
        .i_usb_trans_ctrl_crc5_error     (crc5_error),
        .i_usb_trans_ctrl_rx_valid       (rx_valid),
        .i_usb_trans_ctrl_rx_eop         (rx_eop),
        .i_usb_trans_ctrl_crc16_error    (crc16_error),
        .i_usb_trans_ctrl_ep_stall       (ep_stall),
        .i_usb_trans_ctrl_ep_tx_ready    (ep_tx_ready),
        .i_usb_trans_ctrl_ep_rx_ready    (ep_rx_ready),
        .i_usb_trans_ctrl_tx_done        (tx_done),
        .o_usb_trans_ctrl_tx_pid         (tx_pid),
        .o_usb_trans_ctrl_tx_req         (tx_req),
        .o_usb_trans_ctrl_tx_is_data     (tx_is_data),
        .o_usb_trans_ctrl_ep_num         (ep_num),
        .o_usb_trans_ctrl_rx_data_en     (rx_data_en),
        .o_usb_trans_ctrl_rx_commit      (rx_commit),
        .o_usb_trans_ctrl_rx_handshake_on(rx_handshake_on),
        .o_usb_trans_ctrl_sof            (sof),
        .o_usb_trans_ctrl_trans_done     (trans_done),
        .o_usb_trans_ctrl_trans_err      (trans_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_req) begin
                n_req = n_req + 1;
                m_pid = tx_pid;
                m_isd = tx_is_data;
                m_ep  = ep_num;
            end
            if (rx_commit)  n_commit = n_commit + 1;
            if (sof)        n_sof = n_sof + 1;
            if (trans_done) n_done = n_done + 1;
            if (trans_err)  n_err = n_err + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn_id, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pid(input logic [3:0] p);
        rx_pid    = p;
        rx_pid_en = 1'b1;
        cyc();
        rx_pid_en = 1'b0;
    endtask

    task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input bit c5);
        send_pid(p);
        rx_valid = 1'b1;
        cyc();
        rx_eop  = 1'b1;
        rx_addr = a;
        cyc();
        rx_valid   = 1'b0;
        rx_eop     = 1'b0;
        rx_endp    = e;
        crc5_error = c5;
        cyc();
        crc5_error = 1'b0;
    endtask

    task automatic send_data(input logic [3:0] p, input int nbytes, input bit c16);
        send_pid(p);
        check_val("rx_data_en_on", {31'd0, rx_data_en}, 32'd1);
        rx_valid = 1'b1;
        for (int i = 1; i < nbytes; i++) cyc();
        rx_eop = 1'b1;
        cyc();
        rx_valid    = 1'b0;
        rx_eop      = 1'b0;
        crc16_error = c16;
        cyc();
        crc16_error = 1'b0;
        check_val("rx_data_en_off", {31'd0, rx_data_en}, 32'd0);
    endtask

    // kind: 0=SETUP 1=OUT 2=IN 3=SOF
    task automatic run_txn(input int kind, input logic [3:0] ep, input logic [6:0] addr,
                           input bit c5, input bit c16, input bit dpid1, input bit ack);
        int b_req, b_commit, b_sof, b_done, b_err, k;
        logic [3:0] tpid, exp_pid;
        bit live, drx, exp_req, exp_isd;
        int exp_commit, exp_sof, exp_done, exp_err;

        b_req = n_req; b_commit = n_commit; b_sof = n_sof; b_done = n_done; b_err = n_err;
        tpid = (kind == 0) ? PID_SETUP : (kind == 1) ? PID_OUT : (kind == 2) ? PID_IN : PID_SOF;
        exp_req = 0; exp_isd = 0; exp_pid = '0;
        exp_commit = 0; exp_sof = 0; exp_done = 0; exp_err = 0;

        live = !c5 && (kind != 3) && (addr == self_addr);
        drx  = live && (kind <= 1);
        if (!c5 && kind == 3) exp_sof = 1;
        if (live && kind == 0) model_tog[ep] = 1'b0;
        if (drx) begin
            if (c16) begin
                exp_err = 1;
            end else begin
                exp_req = 1; exp_done = 1;
                if (kind == 0) begin
                    exp_pid = PID_ACK; exp_commit = 1; model_tog[ep] = 1'b1;
                end else if (ep_stall[ep]) begin
                    exp_pid = PID_STALL;
                end else if (!ep_rx_ready[ep]) begin
                    exp_pid = PID_NAK;
                end else begin
                    exp_pid = PID_ACK;
                    if (dpid1 == model_tog[ep]) begin
                        exp_commit = 1; model_tog[ep] = ~model_tog[ep];
                    end
                end
            end
        end else if (live && kind == 2) begin
            exp_req = 1;
            if (ep_stall[ep]) begin
                exp_pid = PID_STALL; exp_done = 1;
            end else if (!ep_tx_ready[ep]) begin
                exp_pid = PID_NAK; exp_done = 1;
            end else begin
                exp_isd = 1;
                exp_pid = model_tog[ep] ? PID_DATA1 : PID_DATA0;
                if (ack) begin
                    exp_done = 1; model_tog[ep] = ~model_tog[ep];
                end else begin
                    exp_err = 1;
                end
            end
        end

        send_token(tpid, addr, ep, c5);
        if (drx) send_data(dpid1 ? PID_DATA1 : PID_DATA0, 1 + $urandom_range(0, 3), c16);
        repeat (2) cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        if (exp_isd) begin
            cyc();
            check_val("hs_on", {31'd0, rx_handshake_on}, 32'd1);
            if (ack) begin
                send_pid(PID_ACK);
            end else begin
                k = 0;
                while (n_err == b_err && k < 300) begin
                    cyc();
                    k++;
                end
                check_val("timeout_win", {31'd0, (k >= 99 && k <= 103)}, 32'd1);
            end
        end
        repeat (2) cyc();
        check_val("hs_off", {31'd0, rx_handshake_on}, 32'd0);
        check_val("tx_req_cnt", n_req - b_req, exp_req);
        check_val("commit_cnt", n_commit - b_commit, exp_commit);
        check_val("sof_cnt", n_sof - b_sof, exp_sof);
        check_val("done_cnt", n_done - b_done, exp_done);
        check_val("err_cnt", n_err - b_err, exp_err);
        if (exp_req) begin
            check_val("tx_pid", m_pid, exp_pid);
            check_val("tx_is_data", m_isd, exp_isd);
            check_val("ep_num", m_ep, ep);
        end
        $display("txn %0d kind=%0d ep=%0d addr=%0h c5=%0d c16=%0d d1=%0d ack=%0d exp_pid=%0h req=%0d done=%0d err=%0d",
                 txn_id, kind, ep, addr, c5, c16, dpid1, ack, exp_pid, exp_req, exp_done, exp_err);
        txn_id++;
    endtask

    function automatic logic [15:0] out_bus();
        return {tx_pid, tx_req, tx_is_data, ep_num, rx_data_en, rx_commit,
                rx_handshake_on, sof, trans_done, trans_err};
    endfunction

    initial begin
        int kind;
        repeat (3) cyc();
        check_val("reset_outs", {16'd0, out_bus()}, 32'd0);
        rst_n = 1'b1;
        cyc();

        ep_stall = 16'h0008; ep_tx_ready = 16'hFFEF; ep_rx_ready = 16'hFFFF;
        run_txn(0, 4'd0, 7'h05, 0, 0, 0, 0);   // SETUP ep0 + DATA0 -> ACK, commit
        run_txn(1, 4'd2, 7'h05, 0, 0, 1, 0);   // OUT ep2 DATA1, toggle 0 -> ACK, no commit
        run_txn(2, 4'd1, 7'h05, 0, 0, 0, 1);   // IN ep1 DATA0, ACKed
        run_txn(2, 4'd1, 7'h05, 0, 0, 0, 0);   // IN ep1 DATA1, timeout
        run_txn(2, 4'd3, 7'h05, 0, 0, 0, 0);   // stalled -> STALL
        run_txn(2, 4'd4, 7'h05, 0, 0, 0, 0);   // not ready -> NAK
        run_txn(1, 4'd2, 7'h05, 1, 0, 0, 0);   // bad CRC5 -> silent
        run_txn(1, 4'd2, 7'h06, 0, 0, 0, 0);   // wrong address -> silent
        run_txn(3, 4'd0, 7'h06, 0, 0, 0, 0);   // SOF ignores address

        // Reset during DATA_RX
        send_token(PID_SETUP, 7'h05, 4'd0, 1'b0);
        send_pid(PID_DATA0);
        rx_valid = 1'b1;
        cyc();
        rst_n = 1'b0;
        #2;
        check_val("midrst_outs", {16'd0, out_bus()}, 32'd0);
        model_tog = '0;
        rx_valid = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        run_txn(2, 4'd1, 7'h05, 0, 0, 0, 1);   // toggle cleared -> DATA0 again
        run_txn(0, 4'd0, 7'h05, 0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            ep_stall    = 16'($urandom & $urandom & $urandom);
            ep_tx_ready = 16'($urandom | $urandom);
            ep_rx_ready = 16'($urandom | $urandom);
            kind = int'($urandom_range(0, 3));
            run_txn(kind, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0) ? 7'h06 : 7'h05,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
